// File: rtl/rob_retire_pkg.sv
// Shared ROB/rename types and sizing.
// Imported by the ROB retire stage and its free-mask helper.
package rob_retire_pkg;
   localparam int DEPTH    = 16;
   localparam int IDX_W    = 4;
   localparam int PREG_W   = 6;
   localparam int NUM_PREG = 64;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [PREG_W-1:0] dr_p;
      logic [PREG_W-1:0] old_dr;
   } rob_entry_t;
endpackage

// File: rtl/rob_free_mask_gen.sv
// Turns up to two retiring entries into a preg free mask.
// p0 is never freed.
module rob_free_mask_gen
   import rob_retire_pkg::*;
(
   input  logic [1:0]          retire,
   input  logic [1:0]          has_dest,
   input  logic [2*PREG_W-1:0] old_dr,
   output logic [NUM_PREG-1:0] mask
);
   always_comb begin
      mask = '0;
      for (int k = 0; k < 2; k++) begin
         if (retire[k] && has_dest[k]) begin
            mask[old_dr[k*PREG_W +: PREG_W]] = 1'b1;
         end
      end
      mask[0] = 1'b0;
   end
endmodule

// File: rtl/rob_retire.sv
// In-order ROB: dispatch at tail, out-of-order completion,
// dual in-order retire at head returning old mappings.
module rob_retire
   import rob_retire_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                dispatch_valid,
   input  logic                dispatch_has_dest,
   input  logic [PREG_W-1:0]   dispatch_dr_p,
   input  logic [PREG_W-1:0]   dispatch_old_dr,
   output logic                dispatch_ready,
   output logic [IDX_W-1:0]    alloc_idx,
   input  logic [1:0]          complete_valid,
   input  logic [2*IDX_W-1:0]  complete_idx,
   output logic [NUM_PREG-1:0] retire_from_ROB,
   output logic [1:0]          retire_count,
   output logic [IDX_W:0]      rob_count,
   output logic                rob_empty,
   output logic                rob_full
);
   rob_entry_t rob_q [DEPTH];

   logic [IDX_W-1:0]    head_q;
   logic [IDX_W-1:0]    tail_q;
   logic [IDX_W:0]      count_q;
   logic [IDX_W-1:0]    head1;
   logic                r0;
   logic                r1;
   logic                accept;
   logic [1:0]          ret_n;
   logic [NUM_PREG-1:0] free_mask;

   assign head1 = head_q + 1'b1;

   // Retire looks only at registered done bits.
   assign r0 = rob_q[head_q].valid && rob_q[head_q].done;
   assign r1 = r0 && rob_q[head1].valid && rob_q[head1].done;
   assign ret_n = {1'b0, r0} + {1'b0, r1};

   assign rob_full       = count_q == (IDX_W+1)'(DEPTH);
   assign rob_empty      = count_q == '0;
   assign dispatch_ready = !rob_full;
   assign accept         = dispatch_valid && dispatch_ready;
   assign alloc_idx      = tail_q;
   assign rob_count      = count_q;

   rob_free_mask_gen u_mask (
      .retire   ({r1, r0}),
      .has_dest ({rob_q[head1].has_dest,
                  rob_q[head_q].has_dest}),
      .old_dr   ({rob_q[head1].old_dr,
                  rob_q[head_q].old_dr}),
      .mask     (free_mask)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i] <= '0;
         end
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         retire_from_ROB <= '0;
         retire_count    <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (complete_valid[p] &&
                rob_q[complete_idx[p*IDX_W +: IDX_W]].valid) begin
               rob_q[complete_idx[p*IDX_W +: IDX_W]].done <= 1'b1;
            end
         end
         if (r0) begin
            rob_q[head_q].valid <= 1'b0;
            rob_q[head_q].done  <= 1'b0;
         end
         if (r1) begin
            rob_q[head1].valid <= 1'b0;
            rob_q[head1].done  <= 1'b0;
         end
         // The tail slot is never valid while dispatch is open.
         if (accept) begin
            rob_q[tail_q] <= '{valid:    1'b1,
                               done:     1'b0,
                               has_dest: dispatch_has_dest,
                               dr_p:     dispatch_dr_p,
                               old_dr:   dispatch_old_dr};
         end
         head_q  <= head_q + IDX_W'(ret_n);
         tail_q  <= tail_q + IDX_W'(accept);
         count_q <= count_q + (IDX_W+1)'(accept)
                    - (IDX_W+1)'(ret_n);
         retire_from_ROB <= free_mask;
         retire_count    <= ret_n;
      end
   end
endmodule

// File: tb/tb_rob_retire.sv
// Randomized and directed bench for rob_retire.
// Reference: program-order queue of in-flight instructions.
module tb_rob_retire;
   import rob_retire_pkg::*;

   logic                clk = 1'b0;
   logic                rstn;
   logic                dispatch_valid;
   logic                dispatch_has_dest;
   logic [PREG_W-1:0]   dispatch_dr_p;
   logic [PREG_W-1:0]   dispatch_old_dr;
   logic                dispatch_ready;
   logic [IDX_W-1:0]    alloc_idx;
   logic [1:0]          complete_valid;
   logic [2*IDX_W-1:0]  complete_idx;
   logic [NUM_PREG-1:0] retire_from_ROB;
   logic [1:0]          retire_count;
   logic [IDX_W:0]      rob_count;
   logic                rob_empty;
   logic                rob_full;

   rob_retire dut (
      .clk               (clk),
      .rstn              (rstn),
      .dispatch_valid    (dispatch_valid),
      .dispatch_has_dest (dispatch_has_dest),
      .dispatch_dr_p     (dispatch_dr_p),
      .dispatch_old_dr   (dispatch_old_dr),
      .dispatch_ready    (dispatch_ready),
      .alloc_idx         (alloc_idx),
      .complete_valid    (complete_valid),
      .complete_idx      (complete_idx),
      .retire_from_ROB   (retire_from_ROB),
      .retire_count      (retire_count),
      .rob_count         (rob_count),
      .rob_empty         (rob_empty),
      .rob_full          (rob_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       idx;
      bit       hd;
      int       odr;
      bit       done;
   } minst_t;

   minst_t q[$];
   int     tail;
   int     total = 0;
   int     bad = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      dispatch_valid    = 1'b0;
      dispatch_has_dest = 1'b0;
      dispatch_dr_p     = '0;
      dispatch_old_dr   = '0;
      complete_valid    = '0;
      complete_idx      = '0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      q.delete();
      tail = 0;
      chk("rst_mask", retire_from_ROB, 64'd0);
      chk("rst_rcnt", 64'(retire_count), 64'd0);
      chk("rst_cnt", 64'(rob_count), 64'd0);
      chk("rst_empty", 64'(rob_empty), 64'd1);
      chk("rst_full", 64'(rob_full), 64'd0);
      chk("rst_ready", 64'(dispatch_ready), 64'd1);
      chk("rst_alloc", 64'(alloc_idx), 64'd0);
   endtask

   // One clock: drive, check comb outputs, advance model, check regs.
   task automatic step(input bit dv, input bit hd,
                       input int drp, input int odr,
                       input bit [1:0] cv,
                       input int c0, input int c1);
      int          nret;
      bit          room;
      logic [63:0] m;
      int          cidx [2];
      minst_t      e;
      dispatch_valid    = dv;
      dispatch_has_dest = hd;
      dispatch_dr_p     = PREG_W'(drp);
      dispatch_old_dr   = PREG_W'(odr);
      complete_valid    = cv;
      complete_idx      = {IDX_W'(c1), IDX_W'(c0)};
      cidx[0] = c0;
      cidx[1] = c1;
      #4;
      room = q.size() < DEPTH;
      chk("ready", 64'(dispatch_ready), 64'(room));
      chk("alloc", 64'(alloc_idx), 64'(tail));
      nret = 0;
      m = '0;
      for (int k = 0; k < 2; k++) begin
         if (nret == k && q.size() > k && q[k].done) nret++;
      end
      for (int k = 0; k < nret; k++) begin
         if (q[k].hd && q[k].odr != 0) m[q[k].odr] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
         if (cv[p]) begin
            foreach (q[k]) if (q[k].idx == cidx[p]) q[k].done = 1;
         end
      end
      for (int k = 0; k < nret; k++) void'(q.pop_front());
      if (dv && room) begin
         e.idx  = tail;
         e.hd   = hd;
         e.odr  = odr;
         e.done = 0;
         q.push_back(e);
         tail = (tail + 1) % DEPTH;
      end
      @(posedge clk);
      #1;
      chk("mask", retire_from_ROB, m);
      chk("rcnt", 64'(retire_count), 64'(nret));
      chk("cnt", 64'(rob_count), 64'(q.size()));
      chk("empty", 64'(rob_empty), 64'(q.size() == 0));
      chk("full", 64'(rob_full), 64'(q.size() == DEPTH));
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 2'b00, 0, 0);
   endtask

   initial begin
      int pc0;
      int pc1;
      idle_inputs();
      do_reset();

      // single instruction
      step(1, 1, 33, 5, 2'b00, 0, 0);
      step(0, 0, 0, 0, 2'b01, 0, 0);
      nop();
      chk("single_mask", retire_from_ROB, 64'h20);
      chk("single_rcnt", 64'(retire_count), 64'd1);
      nop();
      chk("single_pulse", retire_from_ROB, 64'd0);

      // out-of-order completion
      do_reset();
      step(1, 1, 40, 7, 2'b00, 0, 0);
      step(1, 1, 41, 9, 2'b00, 0, 0);
      step(0, 0, 0, 0, 2'b10, 0, 1);
      nop();
      nop();
      step(0, 0, 0, 0, 2'b01, 0, 0);
      nop();
      chk("ooo_mask", retire_from_ROB, 64'h280);
      chk("ooo_rcnt", 64'(retire_count), 64'd2);
      nop();

      // fill, stall, drain one
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, 1, 20 + i, 1 + i, 2'b00, 0, 0);
      chk("full_flag", 64'(rob_full), 64'd1);
      step(1, 1, 50, 50, 2'b00, 0, 0);
      step(0, 0, 0, 0, 2'b01, 0, 0);
      nop();
      nop();
      chk("full_drain", 64'(dispatch_ready), 64'd1);

      // steady wrap-around stream
      do_reset();
      for (int i = 0; i < 42; i++) begin
         if (i >= 2) begin
            step(i < 40, 1, (i % 60) + 2, (i % 63) + 1,
                 2'b01, (i - 2) % DEPTH, 0);
         end else begin
            step(1, 1, i + 2, i + 1, 2'b00, 0, 0);
         end
      end
      repeat (3) nop();
      chk("wrap_empty", 64'(rob_empty), 64'd1);

      // store and p0 suppression
      do_reset();
      step(1, 0, 0, 12, 2'b00, 0, 0);
      step(1, 1, 30, 0, 2'b00, 0, 0);
      step(0, 0, 0, 0, 2'b11, 0, 1);
      nop();
      chk("supp_mask", retire_from_ROB, 64'd0);
      chk("supp_rcnt", 64'(retire_count), 64'd2);

      // random traffic with occasional reset
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         pc0 = int'($urandom_range(0, DEPTH - 1));
         pc1 = int'($urandom_range(0, DEPTH - 1));
         if (q.size() > 0 && $urandom_range(0, 1) == 1)
            pc0 = q[$urandom_range(0, q.size() - 1)].idx;
         if (q.size() > 0 && $urandom_range(0, 2) == 0)
            pc1 = q[0].idx;
         step($urandom_range(0, 3) != 0,
              1'($urandom), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)),
              2'($urandom_range(0, 3) & $urandom_range(0, 3)),
              pc0, pc1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer (ROB) retire stage; the consumer end of rename's allocation flow.
- Dispatch writes one entry per cycle (new dest preg, previous mapping old_dr).
- Functional units mark entries complete out of order.
- Head retires up to two completed entries per cycle in program order and returns each retired entry's old_dr to the free pool as a one-cycle bit in the 64-bit retire_from_ROB mask.

Parameters:
DEPTH, 16, number of ROB entries (power of two)
IDX_W, 4, log2(DEPTH), entry index width
PREG_W, 6, physical register number width
NUM_PREG, 64, physical register count; width of retire mask

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
dispatch_valid  in  1  rename presents an instruction this cycle
dispatch_has_dest  in  1  instruction writes a register (0 for store/NOP)
dispatch_dr_p  in  PREG_W  newly allocated dest preg
dispatch_old_dr  in  PREG_W  preg previously mapped to the arch dest
dispatch_ready  out  1  ROB not full; dispatch accepted iff valid && ready
alloc_idx  out  IDX_W  ROB index given to the dispatching instruction (current tail)
complete_valid  in  2  per-port completion strobe (two FU write-back ports)
complete_idx  in  2*IDX_W  per-port completed ROB index, port0 in [IDX_W-1:0]
retire_from_ROB  out  NUM_PREG  registered mask; bit p=1 frees preg p this cycle
retire_count  out  2  registered number of entries retired last cycle (0..2)
rob_count  out  IDX_W+1  registered occupancy
rob_empty  out  1  rob_count==0
rob_full  out  1  rob_count==DEPTH

Behaviour:
- Reset (rstn=0 at posedge):
  - head=tail=0, count=0.
  - All entry valid/done bits cleared.
  - retire_from_ROB=0, retire_count=0, rob_count=0, rob_empty=1, rob_full=0, dispatch_ready=1.
  - Reset mid-operation discards all entries; no retire pulse is emitted for them.
- Entry fields: valid, done, has_dest, dr_p, old_dr.
- dispatch_ready = !rob_full, computed from registered count only.
  - A full ROB blocks dispatch even if a retire occurs in the same cycle.
- Dispatch accept:
  - Entry[tail] <= {valid=1, done=0, fields}; tail <= tail+1 mod DEPTH.
  - alloc_idx = tail, combinational.
- Completion:
  - For each port with complete_valid, entry[idx].done <= 1 only if entry[idx].valid.
  - Completion to an invalid entry is ignored.
  - Both ports naming the same idx is equivalent to one.
  - Completion to the idx being dispatched in the same cycle is ignored (entry not yet valid).
- Retire evaluation uses registered done bits only. A completion arriving in cycle N can retire no earlier than cycle N+1 edge.
  - r0 = entry[head].valid && entry[head].done.
  - r1 = r0 && entry[head+1].valid && entry[head+1].done.
  - Retired entries: valid <= 0, done <= 0; head <= head + r0 + r1 mod DEPTH.
- Retire output, registered, valid one cycle after the retire decision (pulse, cleared the following cycle if nothing retires):
  - retire_from_ROB bit old_dr is set for each retired entry with has_dest=1 and old_dr != 0.
  - p0 is never set.
  - Two retirements with the same old_dr OR into one bit.
  - retire_count = r0 + r1.
- Occupancy: count <= count + accepted - (r0+r1). Dispatch and retire in the same cycle are both honoured.
- Pointers wrap modulo DEPTH. head==tail is disambiguated by count (0 = empty, DEPTH = full).
- No flush/mispredict recovery in this block.

Decomposition:
- Shared package holds:
  - DEPTH, IDX_W, PREG_W, NUM_PREG constants.
  - rob_entry_t struct {valid, done, has_dest, dr_p, old_dr}; the same PREG_W is used by rename.
- One natural sub-module: rob_free_mask_gen.
  - Combinational; takes up to two (retire, has_dest, old_dr) tuples and produces the NUM_PREG-bit mask with the p0 suppression.
  - Instantiated ahead of the output register.

Test Plan:
- Reset: assert rstn=0 two cycles.
  - rob_empty=1, dispatch_ready=1, retire_from_ROB=0, alloc_idx=0.
- Single instruction: dispatch dr_p=33, old_dr=5, has_dest=1 (alloc_idx=0); complete idx 0 next cycle.
  - Two cycles after completion, retire_from_ROB has only bit 5 set for exactly one cycle; retire_count=1; rob_empty=1.
- Out-of-order completion: dispatch idx 0 (old_dr=7) and idx 1 (old_dr=9); complete idx 1 first, idx 0 three cycles later.
  - No retire until idx 0 done; then one cycle with bits 7 and 9 set, retire_count=2.
- Full/stall: dispatch 16 entries without completion.
  - rob_full=1, dispatch_ready=0, 17th dispatch_valid ignored, tail unchanged.
  - Complete idx 0, retire, then dispatch_ready returns to 1.
- Wrap-around: steady stream of 40 instructions, each completed two cycles after dispatch.
  - alloc_idx sequence 0..15,0..; every old_dr freed exactly once, in program order.
  - rob_count never exceeds 16.
- Suppression: retire store (has_dest=0, old_dr=12) and an instruction with old_dr=0.
  - retire_count=2, retire_from_ROB=0.
